// File: rtl/tcm_dport_arbiter_pkg.sv
// Shared types and constants for the TCM data-port arbiter.
package tcm_dport_arbiter_pkg;

  localparam int unsigned MEM_D_TAG_W = 11;

  typedef enum logic [1:0] {
    ARB_IDLE   = 2'd0,
    ARB_LOCK_0 = 2'd1,
    ARB_LOCK_1 = 2'd2
  } dport_arb_state_t;

  // Request fields routed from a master to the memory port. The tag travels
  // separately because its width is a module parameter.
  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data_wr;
    logic        rd;
    logic [3:0]  wr;
    logic        cacheable;
    logic        invalidate;
    logic        writeback;
    logic        flush;
  } mem_d_req_t;

  // A master is requesting when any access or maintenance strobe is set.
  function automatic logic req_active(mem_d_req_t r);
    return r.rd | (|r.wr) | r.flush | r.invalidate | r.writeback;
  endfunction

endpackage

// File: rtl/tcm_dport_if.sv
// Data-port bus: request from master to slave, accept and response back.
interface tcm_dport_if #(
  parameter int unsigned TAG_W = 11
) ();
  logic [31:0]      addr;
  logic [31:0]      data_wr;
  logic             rd;
  logic [3:0]       wr;
  logic             cacheable;
  logic             invalidate;
  logic             writeback;
  logic             flush;
  logic [TAG_W-1:0] req_tag;
  logic             accept;
  logic             ack;
  logic             error;
  logic [31:0]      data_rd;
  logic [TAG_W-1:0] resp_tag;

  modport master (
    output addr, data_wr, rd, wr, cacheable, invalidate, writeback, flush, req_tag,
    input  accept, ack, error, data_rd, resp_tag
  );

  modport slave (
    input  addr, data_wr, rd, wr, cacheable, invalidate, writeback, flush, req_tag,
    output accept, ack, error, data_rd, resp_tag
  );
endinterface

// File: rtl/tcm_route_fifo.sv
// In-order FIFO of 1-bit master ids, one entry per accepted-but-unacked request.
module tcm_route_fifo #(
  parameter int unsigned DEPTH = 4,
  localparam int unsigned PtrW = $clog2(DEPTH),
  localparam int unsigned CntW = $clog2(DEPTH + 1)
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            push_i,
  input  logic            push_id_i,
  input  logic            pop_i,
  output logic            head_id_o,
  output logic            full_o,
  output logic            empty_o,
  output logic [CntW-1:0] count_o
);

  logic [DEPTH-1:0] r_mem;
  logic [PtrW-1:0]  r_wptr;
  logic [PtrW-1:0]  r_rptr;
  logic [CntW-1:0]  r_count;
  logic             w_push;
  logic             w_pop;

  assign full_o    = (r_count == CntW'(DEPTH));
  assign empty_o   = (r_count == '0);
  assign count_o   = r_count;
  assign head_id_o = r_mem[r_rptr];
  assign w_push    = push_i & ~full_o;
  assign w_pop     = pop_i & ~empty_o;

  // Storage, pointers (natural wrap) and occupancy count.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_mem   <= '0;
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wptr] <= push_id_i;
        r_wptr        <= r_wptr + PtrW'(1);
      end
      if (w_pop) begin
        r_rptr <= r_rptr + PtrW'(1);
      end
      if (w_push && !w_pop) begin
        r_count <= r_count + CntW'(1);
      end else if (!w_push && w_pop) begin
        r_count <= r_count - CntW'(1);
      end
    end
  end

endmodule

// File: rtl/tcm_dport_arbiter.sv
// Round-robin arbiter sharing the TCM data port between two masters, with
// in-order response routing back to the issuing master.
module tcm_dport_arbiter
  import tcm_dport_arbiter_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned TAG_W = MEM_D_TAG_W
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  tcm_dport_if.slave                 m0,
  tcm_dport_if.slave                 m1,
  tcm_dport_if.master                s,
  output logic [$clog2(DEPTH+1)-1:0] outstanding_o,
  output logic                       stray_ack_o
);

  dport_arb_state_t r_state, w_state_next;
  logic             r_rr_last, w_rr_next;
  logic             w_grant_vld, w_grant_id;
  logic             w_push, w_pop;
  logic             w_full, w_empty, w_head_id;
  logic             w_req0, w_req1;
  logic             w_ack0, w_ack1;
  logic             r_stray;
  logic [31:0]      r_data0, r_data1;
  logic [TAG_W-1:0] r_tag0, r_tag1;
  mem_d_req_t       w_m0_req, w_m1_req, w_sel_req;

  assign w_m0_req = '{addr: m0.addr, data_wr: m0.data_wr, rd: m0.rd, wr: m0.wr,
                      cacheable: m0.cacheable, invalidate: m0.invalidate,
                      writeback: m0.writeback, flush: m0.flush};
  assign w_m1_req = '{addr: m1.addr, data_wr: m1.data_wr, rd: m1.rd, wr: m1.wr,
                      cacheable: m1.cacheable, invalidate: m1.invalidate,
                      writeback: m1.writeback, flush: m1.flush};
  assign w_req0   = req_active(w_m0_req);
  assign w_req1   = req_active(w_m1_req);

  tcm_route_fifo #(
    .DEPTH(DEPTH)
  ) u_route_fifo (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .push_i    (w_push),
    .push_id_i (w_grant_id),
    .pop_i     (w_pop),
    .head_id_o (w_head_id),
    .full_o    (w_full),
    .empty_o   (w_empty),
    .count_o   (outstanding_o)
  );

  // FSM and round-robin state registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state   <= ARB_IDLE;
      r_rr_last <= 1'b1;
    end else begin
      r_state   <= w_state_next;
      r_rr_last <= w_rr_next;
    end
  end

  // Grant selection, lock tracking and FIFO push.
  always_comb begin
    w_state_next = r_state;
    w_rr_next    = r_rr_last;
    w_grant_vld  = 1'b0;
    w_grant_id   = 1'b0;
    w_push       = 1'b0;
    case (r_state)
      ARB_IDLE: begin
        // A full routing FIFO blocks new grants even if an ack pops this cycle.
        if (!w_full) begin
          if (w_req0 && w_req1) begin
            w_grant_vld = 1'b1;
            w_grant_id  = ~r_rr_last;
          end else if (w_req0) begin
            w_grant_vld = 1'b1;
          end else if (w_req1) begin
            w_grant_vld = 1'b1;
            w_grant_id  = 1'b1;
          end
        end
      end
      ARB_LOCK_0: begin
        if (w_req0) w_grant_vld = 1'b1;
        else        w_state_next = ARB_IDLE;
      end
      ARB_LOCK_1: begin
        if (w_req1) begin
          w_grant_vld = 1'b1;
          w_grant_id  = 1'b1;
        end else begin
          w_state_next = ARB_IDLE;
        end
      end
      default: w_state_next = ARB_IDLE;
    endcase
    // Keep all strobes quiet while reset is asserted.
    if (rst_i) w_grant_vld = 1'b0;
    if (w_grant_vld) begin
      if (s.accept) begin
        w_push       = 1'b1;
        w_rr_next    = w_grant_id;
        w_state_next = ARB_IDLE;
      end else begin
        w_state_next = w_grant_id ? ARB_LOCK_1 : ARB_LOCK_0;
      end
    end
  end

  // Request mux towards the memory port; all zero when nobody is granted.
  always_comb begin
    w_sel_req = '0;
    s.req_tag = '0;
    if (w_grant_vld) begin
      w_sel_req = w_grant_id ? w_m1_req : w_m0_req;
      s.req_tag = w_grant_id ? m1.req_tag : m0.req_tag;
    end
  end

  assign s.addr       = w_sel_req.addr;
  assign s.data_wr    = w_sel_req.data_wr;
  assign s.rd         = w_sel_req.rd;
  assign s.wr         = w_sel_req.wr;
  assign s.cacheable  = w_sel_req.cacheable;
  assign s.invalidate = w_sel_req.invalidate;
  assign s.writeback  = w_sel_req.writeback;
  assign s.flush      = w_sel_req.flush;

  assign m0.accept = w_grant_vld & ~w_grant_id & s.accept;
  assign m1.accept = w_grant_vld & w_grant_id & s.accept;

  // Response demux: route each ack to the master at the FIFO head.
  assign w_pop  = s.ack & ~w_empty & ~rst_i;
  assign w_ack0 = w_pop & ~w_head_id;
  assign w_ack1 = w_pop & w_head_id;

  assign m0.ack      = w_ack0;
  assign m0.error    = w_ack0 & s.error;
  assign m0.data_rd  = w_ack0 ? s.data_rd : r_data0;
  assign m0.resp_tag = w_ack0 ? s.resp_tag : r_tag0;
  assign m1.ack      = w_ack1;
  assign m1.error    = w_ack1 & s.error;
  assign m1.data_rd  = w_ack1 ? s.data_rd : r_data1;
  assign m1.resp_tag = w_ack1 ? s.resp_tag : r_tag1;
  assign stray_ack_o = r_stray;

  // Hold last delivered response per master; latch stray acks.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_data0 <= '0;
      r_tag0  <= '0;
      r_data1 <= '0;
      r_tag1  <= '0;
      r_stray <= 1'b0;
    end else begin
      if (w_ack0) begin
        r_data0 <= s.data_rd;
        r_tag0  <= s.resp_tag;
      end
      if (w_ack1) begin
        r_data1 <= s.data_rd;
        r_tag1  <= s.resp_tag;
      end
      if (s.ack && w_empty) r_stray <= 1'b1;
    end
  end

endmodule
